// File: rtl/dec_5x32_pkg.sv
// Shared constants for the 5-to-32 decoder slice: select/decode widths and the
// default primitive gate delay in picoseconds.
`timescale 1ps/1ps
package dec_5x32_pkg;
    localparam int SEL_W              = 5;
    localparam int DEC_W              = 32;
    localparam int DEFAULT_GATE_DELAY = 50;
endpackage

// File: rtl/dec_5x32_cells.sv
// Leaf cells for the decoder: gate-level 2-to-4 and 3-to-8 decoders built from
// not/and primitives, and the synchronous-reset D flip-flop cell.
`timescale 1ps/1ps

module dec_2x4 #(
    parameter int GATE_DELAY = 50
) (
    input  logic [1:0] in,
    input  logic       en,
    output wire  [3:0] out
);
    wire [1:0]      in_n;
    wire [1:0][1:0] lit;

    not #(GATE_DELAY) n0 (in_n[0], in[0]);
    not #(GATE_DELAY) n1 (in_n[1], in[1]);

    // lit[1] is the true literal, lit[0] the complement; k's bits pick which.
    assign lit = {in, in_n};

    for (genvar k = 0; k < 4; k++) begin : g_and
        localparam logic [1:0] K = k[1:0];
        and #(GATE_DELAY) a (out[k], en, lit[K[1]][1], lit[K[0]][0]);
    end
endmodule

module dec_3x8 #(
    parameter int GATE_DELAY = 50
) (
    input  logic [2:0] in,
    input  logic       en,
    output wire  [7:0] out
);
    wire [2:0]      in_n;
    wire [1:0][2:0] lit;

    not #(GATE_DELAY) n0 (in_n[0], in[0]);
    not #(GATE_DELAY) n1 (in_n[1], in[1]);
    not #(GATE_DELAY) n2 (in_n[2], in[2]);

    assign lit = {in, in_n};

    for (genvar k = 0; k < 8; k++) begin : g_and
        localparam logic [2:0] K = k[2:0];
        and #(GATE_DELAY) a (out[k], en, lit[K[2]][2], lit[K[1]][1], lit[K[0]][0]);
    end
endmodule

module d_ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end
endmodule

// File: rtl/dec_5x32.sv
// 5-to-32 one-hot decoder: a 2-to-4 stage on in[4:3] enables one of four
// 3-to-8 stages on in[2:0]; out_q is a one-cycle registered copy of out.
`timescale 1ps/1ps
module dec_5x32
    import dec_5x32_pkg::*;
#(
    parameter int GATE_DELAY = DEFAULT_GATE_DELAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] in,
    input  logic             en,
    output logic [DEC_W-1:0] out,
    output logic [DEC_W-1:0] out_q
);
    wire [3:0] grp;

    dec_2x4 #(.GATE_DELAY(GATE_DELAY)) u_hi (
        .in  (in[4:3]),
        .en  (en),
        .out (grp)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lo
        dec_3x8 #(.GATE_DELAY(GATE_DELAY)) u_lo (
            .in  (in[2:0]),
            .en  (grp[g]),
            .out (out[g*8 +: 8])
        );
    end

    // Reset only touches the register bank; the combinational decode is untouched.
    for (genvar b = 0; b < DEC_W; b++) begin : g_ff
        d_ff u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (out[b]),
            .q     (out_q[b])
        );
    end
endmodule

// File: tb/tb_dec_5x32.sv
// Directed bench for dec_5x32: a driver pushes expected out / out_q values into
// queues, and two monitors pop and compare when each output is presented.
`timescale 1ps/1ps
module tb_dec_5x32;
    localparam int PERIOD = 1000;

    logic        clk;
    logic        reset;
    logic [4:0]  in;
    logic        en;
    logic [31:0] out;
    logic [31:0] out_q;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    string       exp_tag[$];
    logic [31:0] reg_exp_q[$];
    string       reg_tag[$];
    event        comb_ev;

    dec_5x32 #(.GATE_DELAY(50)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .en    (en),
        .out   (out),
        .out_q (out_q)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    initial begin
        #(PERIOD * 2000);
        $display("FAIL watchdog: run did not finish within %0d ps", PERIOD * 2000);
        $fatal(1, "watchdog expired");
    end

    // Combinational monitor: compares out whenever the driver presents a vector.
    always @(comb_ev) begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = exp_tag.pop_front();
        total++;
        if (out !== e) begin
            bad++;
            $display("FAIL out %s: got %h want %h", t, out, e);
        end
    end

    // Registered monitor: one pop per clock edge once expectations are queued.
    always @(posedge clk) begin
        logic [31:0] e;
        string       t;
        #1;
        if (reg_exp_q.size() > 0) begin
            e = reg_exp_q.pop_front();
            t = reg_tag.pop_front();
            total++;
            if (out_q !== e) begin
                bad++;
                $display("FAIL out_q %s: got %h want %h", t, out_q, e);
            end
        end
    end

    // Driver: set inputs after a falling edge, check out after 200 ps, and
    // queue the out_q value expected just after the following rising edge.
    task automatic step(input logic [4:0] i, input logic e, input logic r,
                        input logic [31:0] exp_out, input logic [31:0] exp_reg,
                        input string tag);
        @(negedge clk);
        in    = i;
        en    = e;
        reset = r;
        reg_exp_q.push_back(exp_reg);
        reg_tag.push_back(tag);
        #200;
        exp_q.push_back(exp_out);
        exp_tag.push_back(tag);
        ->comb_ev;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        in    = 5'd0;
        en    = 1'b0;

        step(5'd0, 1'b0, 1'b1, 32'h0, 32'h0, "reset_state");

        for (int k = 0; k < 32; k++) begin
            logic [31:0] one_hot;
            one_hot = 32'h1 << k;
            step(5'(k), 1'b1, 1'b0, one_hot, one_hot, $sformatf("sweep_%0d", k));
        end

        step(5'd17, 1'b0, 1'b0, 32'h0, 32'h0, "en0_in17");
        step(5'd31, 1'b0, 1'b0, 32'h0, 32'h0, "en0_in31");

        step(5'd31, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, "top_bit");
        step(5'd0,  1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, "bottom_bit");

        step(5'd5, 1'b1, 1'b1, 32'h0000_0020, 32'h0, "rst_hold_1");
        step(5'd5, 1'b1, 1'b1, 32'h0000_0020, 32'h0, "rst_hold_2");
        step(5'd5, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0020, "rst_release");

        step(5'd3, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, "pipe_in3");
        step(5'd9, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0200, "pipe_in9");

        step(5'd12, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_1000, "mid_pre");
        step(5'd12, 1'b1, 1'b1, 32'h0000_1000, 32'h0,         "mid_reset");
        step(5'd12, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_1000, "mid_post");

        @(posedge clk);
        #5;
        total++;
        if (reg_exp_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending want 0/0",
                     reg_exp_q.size(), exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
